// File: rtl/npu_pkg.sv
// Shared NPU definitions: default score geometry and the argmax frame state encoding.
package npu_pkg;

    localparam int NPU_DATA_W    = 12;
    localparam int NPU_NUM_CLASS = 10;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } argmax_state_e;

endpackage

// File: rtl/argmax_update_cell.sv
// Combinational best/runner-up update for one incoming score of a frame.
module argmax_update_cell
    import npu_pkg::*;
#(
    parameter int DATA_W     = NPU_DATA_W,
    parameter int IDX_W      = 4,
    parameter int SIGNED_CMP = 1
) (
    input  logic              i_first,
    input  logic [DATA_W-1:0] i_score,
    input  logic [IDX_W-1:0]  i_idx,
    input  logic [DATA_W-1:0] i_best,
    input  logic [IDX_W-1:0]  i_best_idx,
    input  logic [DATA_W-1:0] i_runner,
    output logic [DATA_W-1:0] o_best,
    output logic [IDX_W-1:0]  o_best_idx,
    output logic [DATA_W-1:0] o_runner
);

    // Smallest representable score, so any real second score displaces it.
    localparam logic [DATA_W-1:0] FLOOR =
        (SIGNED_CMP != 0) ? {1'b1, {(DATA_W-1){1'b0}}} : '0;

    function automatic logic gt(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        if (SIGNED_CMP != 0)
            return $signed(a) > $signed(b);
        else
            return a > b;
    endfunction

    logic w_beats_best;
    logic w_beats_runner;

    assign w_beats_best   = gt(i_score, i_best);
    assign w_beats_runner = gt(i_score, i_runner);

    always_comb begin
        o_best     = i_best;
        o_best_idx = i_best_idx;
        o_runner   = i_runner;
        if (i_first) begin
            o_best     = i_score;
            o_best_idx = '0;
            o_runner   = FLOOR;
        end else if (w_beats_best) begin
            o_best     = i_score;
            o_best_idx = i_idx;
            o_runner   = i_best;
        end else if (w_beats_runner) begin
            o_runner   = i_score;
        end
    end

endmodule

// File: rtl/argmax_stream.sv
// Streaming argmax over NUM_CLASS scores per frame; reports winner, its score and lead over runner-up.
module argmax_stream
    import npu_pkg::*;
#(
    parameter int  DATA_W     = NPU_DATA_W,
    parameter int  NUM_CLASS  = NPU_NUM_CLASS,
    parameter int  SIGNED_CMP = 1,
    localparam int IDX_W      = (NUM_CLASS > 2) ? $clog2(NUM_CLASS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  out_idx,
    output logic [DATA_W-1:0] out_max,
    output logic [DATA_W:0]   out_margin
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CLASS - 1);

    argmax_state_e     r_state;
    argmax_state_e     w_next_state;
    logic [IDX_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_best;
    logic [IDX_W-1:0]  r_best_idx;
    logic [DATA_W-1:0] r_runner;
    logic              w_beat;
    logic              w_last;
    logic [DATA_W-1:0] w_nxt_best;
    logic [IDX_W-1:0]  w_nxt_best_idx;
    logic [DATA_W-1:0] w_nxt_runner;
    logic [DATA_W:0]   w_best_ext;
    logic [DATA_W:0]   w_runner_ext;

    assign w_beat = in_valid & in_ready;
    assign w_last = (r_cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= ACCUM;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && w_last)
                    w_next_state = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready)
                    w_next_state = ACCUM;
            end
            default: w_next_state = ACCUM;
        endcase
    end

    argmax_update_cell #(
        .DATA_W    (DATA_W),
        .IDX_W     (IDX_W),
        .SIGNED_CMP(SIGNED_CMP)
    ) u_cell (
        .i_first   (r_cnt == '0),
        .i_score   (in_data),
        .i_idx     (r_cnt),
        .i_best    (r_best),
        .i_best_idx(r_best_idx),
        .i_runner  (r_runner),
        .o_best    (w_nxt_best),
        .o_best_idx(w_nxt_best_idx),
        .o_runner  (w_nxt_runner)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_best     <= '0;
            r_best_idx <= '0;
            r_runner   <= '0;
        end else begin
            if (w_beat) begin
                r_best     <= w_nxt_best;
                r_best_idx <= w_nxt_best_idx;
                r_runner   <= w_nxt_runner;
                r_cnt      <= w_last ? '0 : r_cnt + 1'b1;
            end
            if (out_valid && out_ready)
                r_cnt <= '0;
        end
    end

    // One extra bit keeps best - runner-up exact across the full score range.
    always_comb begin
        w_best_ext   = {((SIGNED_CMP != 0) ? r_best[DATA_W-1]   : 1'b0), r_best};
        w_runner_ext = {((SIGNED_CMP != 0) ? r_runner[DATA_W-1] : 1'b0), r_runner};
    end

    assign out_idx    = r_best_idx;
    assign out_max    = r_best;
    assign out_margin = w_best_ext - w_runner_ext;

endmodule

// File: tb/tb_argmax_stream.sv
// Directed bench for argmax_stream: default signed instance plus an 8-bit unsigned 4-class instance.
module tb_argmax_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [11:0] a_in_data, a_out_max;
    logic [3:0]  a_out_idx;
    logic [12:0] a_out_margin;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [7:0]  b_in_data, b_out_max;
    logic [1:0]  b_out_idx;
    logic [8:0]  b_out_margin;

    int errors = 0;
    int checks = 0;

    argmax_stream u_a (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_data   (a_in_data),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_idx   (a_out_idx),
        .out_max   (a_out_max),
        .out_margin(a_out_margin)
    );

    argmax_stream #(
        .DATA_W    (8),
        .NUM_CLASS (4),
        .SIGNED_CMP(0)
    ) u_b (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_idx   (b_out_idx),
        .out_max   (b_out_max),
        .out_margin(b_out_margin)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic a_send(input int d);
        chk("a_in_ready_at_beat", 32'(a_in_ready), 32'd1);
        a_in_valid = 1'b1;
        a_in_data  = d[11:0];
        @(negedge clk);
        a_in_valid = 1'b0;
        a_in_data  = '0;
    endtask

    task automatic b_send(input int d);
        b_in_valid = 1'b1;
        b_in_data  = d[7:0];
        @(negedge clk);
        b_in_valid = 1'b0;
        b_in_data  = '0;
    endtask

    task automatic a_result(input string tag, input int idx, input int mx, input int margin);
        chk({tag, "_valid"},  32'(a_out_valid),  32'd1);
        chk({tag, "_ready"},  32'(a_in_ready),   32'd0);
        chk({tag, "_idx"},    32'(a_out_idx),    32'(idx) & 32'hF);
        chk({tag, "_max"},    32'(a_out_max),    32'(mx) & 32'hFFF);
        chk({tag, "_margin"}, 32'(a_out_margin), 32'(margin) & 32'h1FFF);
    endtask

    task automatic a_release(input string tag);
        a_out_ready = 1'b1;
        @(negedge clk);
        a_out_ready = 1'b0;
        chk({tag, "_release_ready"}, 32'(a_in_ready),  32'd1);
        chk({tag, "_release_valid"}, 32'(a_out_valid), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not reach its end");
        $fatal(1, "timeout");
    end

    initial begin
        int s[10];
        int v31[10] = '{5, -3, 100, 7, 100, 0, -2048, 2047, 1, 9};
        int v33[10] = '{12, -7, 33, 4, 31, -1, 0, 25, 2, 30};

        rst = 1'b1;
        a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready",  32'(a_in_ready),   32'd1);
        chk("rst_out_valid", 32'(a_out_valid),  32'd0);
        chk("rst_idx",       32'(a_out_idx),    32'd0);
        chk("rst_max",       32'(a_out_max),    32'd0);
        chk("rst_margin",    32'(a_out_margin), 32'd0);
        chk("rst_b_ready",   32'(b_in_ready),   32'd1);
        rst = 1'b0;

        // Mixed signed frame, back-to-back beats.
        for (int k = 0; k < 9; k++) a_send(v31[k]);
        chk("f31_not_early", 32'(a_out_valid), 32'd0);
        a_send(v31[9]);
        a_result("f31", 7, 2047, 1947);
        a_release("f31");

        // Tie on the maximum keeps the lower index.
        a_send(3); a_send(40); a_send(40);
        for (int k = 3; k < 10; k++) a_send(1);
        a_result("tie", 1, 40, 0);
        a_release("tie");

        // Valid toggling mid-frame, then a stalled consumer with junk on the input.
        for (int k = 0; k < 10; k++) begin
            a_send(v33[k]);
            if (k < 9) @(negedge clk);
        end
        a_result("gap", 2, 33, 2);
        for (int c = 0; c < 5; c++) begin
            a_in_valid = 1'b1;
            a_in_data  = 12'h7FF;
            @(negedge clk);
            a_result("hold", 2, 33, 2);
        end
        a_in_valid = 1'b0;
        a_release("gap");

        // Reset mid-frame with a competing beat and out_ready in the same cycle.
        a_send(1); a_send(2000); a_send(3); a_send(4); a_send(5);
        rst = 1'b1; a_in_valid = 1'b1; a_in_data = 12'h7FF; a_out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0; a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
        chk("abort_in_ready",  32'(a_in_ready),   32'd1);
        chk("abort_out_valid", 32'(a_out_valid),  32'd0);
        chk("abort_idx",       32'(a_out_idx),    32'd0);
        chk("abort_max",       32'(a_out_max),    32'd0);
        chk("abort_margin",    32'(a_out_margin), 32'd0);
        for (int k = 0; k < 9; k++) a_send(k * 10);
        chk("abort_not_early", 32'(a_out_valid), 32'd0);
        a_send(500);
        a_result("abort", 9, 500, 420);
        a_release("abort");

        // All-equal scores.
        for (int k = 0; k < 10; k++) a_send(-4);
        a_result("equal", 0, -4, 0);
        a_release("equal");

        // Full signed range: margin needs the extra bit.
        a_send(2047);
        for (int k = 1; k < 10; k++) a_send(-2048);
        a_result("span", 0, 2047, 4095);
        a_release("span");

        // Unsigned instance.
        b_send(8'h80); b_send(8'h7F); b_send(8'h00); b_send(8'hFF);
        chk("uns_valid",  32'(b_out_valid),  32'd1);
        chk("uns_idx",    32'(b_out_idx),    32'd3);
        chk("uns_max",    32'(b_out_max),    32'hFF);
        chk("uns_margin", 32'(b_out_margin), 32'h07F);
        b_out_ready = 1'b1; @(negedge clk); b_out_ready = 1'b0;
        chk("uns_release", 32'(b_in_ready), 32'd1);
        b_send(8'hFF); b_send(8'h00); b_send(8'h00); b_send(8'h00);
        chk("uns_span_idx",    32'(b_out_idx),    32'd0);
        chk("uns_span_margin", 32'(b_out_margin), 32'h0FF);
        b_out_ready = 1'b1; @(negedge clk); b_out_ready = 1'b0;

        // Random frames with the consumer always ready: one bubble per frame.
        a_out_ready = 1'b1;
        for (int f = 0; f < 10; f++) begin
            int mx, mi, ru;
            for (int k = 0; k < 10; k++) begin
                if ($urandom_range(0, 3) == 0)
                    s[k] = 2047 - int'($urandom_range(0, 1));
                else
                    s[k] = int'($urandom_range(0, 4095)) - 2048;
            end
            mx = s[0];
            mi = 0;
            for (int k = 1; k < 10; k++)
                if (s[k] > mx) begin mx = s[k]; mi = k; end
            ru = -2048;
            for (int k = 0; k < 10; k++)
                if (k != mi && s[k] > ru) ru = s[k];
            for (int k = 0; k < 10; k++) a_send(s[k]);
            a_result($sformatf("rand%0d", f), mi, mx, mx - ru);
            @(negedge clk);
            chk($sformatf("rand%0d_bubble_ready", f), 32'(a_in_ready),  32'd1);
            chk($sformatf("rand%0d_bubble_valid", f), 32'(a_out_valid), 32'd0);
        end
        a_out_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/argmax_stream.md
ARGMAX_STREAM -- requirements
Module: argmax_stream

Interface
REQ-001 SHALL have parameter DATA_W, default 12, score width in bits.
REQ-002 SHALL have parameter NUM_CLASS, default 10, scores per frame (2..256).
REQ-003 SHALL have parameter SIGNED_CMP, default 1; 1 = two's-complement compare, 0 = unsigned compare.
REQ-004 SHALL derive localparam IDX_W = max(1, clog2(NUM_CLASS)).
REQ-005 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-007 SHALL have port in_valid  input  1  score present on in_data.
REQ-008 SHALL have port in_ready  output  1  block accepts a score this cycle.
REQ-009 SHALL have port in_data  input  DATA_W  class score, in class-index order 0..NUM_CLASS-1.
REQ-010 SHALL have port out_valid  output  1  result held for the consumer.
REQ-011 SHALL have port out_ready  input  1  consumer takes the result.
REQ-012 SHALL have port out_idx  output  IDX_W  winning class index.
REQ-013 SHALL have port out_max  output  DATA_W  winning score.
REQ-014 SHALL have port out_margin  output  DATA_W+1  winner minus runner-up; always >= 0.

Function
REQ-015 SHALL accept a score only when in_valid and in_ready are both high in the same cycle (a beat).
REQ-016 SHALL run two states: ACCUM (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-017 SHALL, in ACCUM, count beats 0..NUM_CLASS-1 with an IDX_W-bit counter; the beat with count NUM_CLASS-1 ends the frame.
REQ-018 SHALL store beat 0 as best (value, index 0) and set runner-up to the most negative value (signed) or 0 (unsigned).
REQ-019 SHALL, for beat k>0, replace best only on strictly greater score (ties keep lower index); the displaced best becomes runner-up; otherwise replace runner-up if the score is strictly greater than it.
REQ-020 SHALL move ACCUM->HOLD on the final beat, so out_valid rises the cycle after the final beat (latency 1 cycle) with out_idx/out_max/out_margin computed including that beat.
REQ-021 SHALL compute out_margin in DATA_W+1 bits with sign-extension (SIGNED_CMP=1) or zero-extension (SIGNED_CMP=0); no overflow at any input.
REQ-022 SHALL hold out_idx, out_max, out_margin stable while out_valid=1 and out_ready=0.
REQ-023 SHALL move HOLD->ACCUM on out_ready=1, clearing the beat count; in_ready rises the next cycle (one bubble per frame).
REQ-024 SHALL ignore in_data and in_valid while in HOLD; no beat is lost or counted.
REQ-025 SHALL tolerate in_valid gaps of any length mid-frame without changing result or count.
REQ-026 SHALL, for all scores equal, report out_idx=0, out_margin=0.

Reset
REQ-027 SHALL, with rst=1 at a clock edge, enter ACCUM with count=0, out_valid=0, in_ready=1 on the following cycle, out_idx=0, out_max=0, out_margin=0.
REQ-028 SHALL discard a partial frame or pending result on reset; rst takes priority over any beat or out_ready that cycle.

Structure
REQ-029 SHALL place the state encoding (ACCUM, HOLD) and default DATA_W/NUM_CLASS constants in the shared NPU package used by the adder-tree blocks.
REQ-030 SHALL implement compare-and-update (best/runner-up, signedness by parameter) as one sub-module, argmax_update_cell, instantiated once.

Verification
REQ-031 Defaults, scores 5,-3,100,7,100,0,-2048,2047,1,9 back-to-back -> out_valid 1 cycle after beat 9; out_idx=7, out_max=2047, out_margin=1947.
REQ-032 Defaults, scores 3,40,40,1,...,1 -> out_idx=1, out_max=40, out_margin=0 (tie keeps lower index).
REQ-033 Frame with in_valid toggling 1/0 each cycle, out_ready held 0 for 5 cycles -> in_ready=0 and outputs stable throughout HOLD; next frame accepted after out_ready.
REQ-034 rst=1 after beat 4 of a frame, then full new frame with max at index 9 -> out_idx=9; no stale data from aborted frame.
REQ-035 SIGNED_CMP=0, DATA_W=8, NUM_CLASS=4, scores 0x80,0x7F,0x00,0xFF -> out_idx=3, out_max=0xFF, out_margin=0x07F.
REQ-036 Ten consecutive random frames with out_ready=1 -> each result matches a reference model; exactly one bubble cycle between frames.
